uart_rx_sipo: RTL and testbench
===============================

// Module: uart_rx_sipo
// PURPOSE
//  Receive-side serial-in/parallel-out stage for the UART. Consumes the serial line driven by the Tx
//  PISO, in the same frame format: start 0, data LSB first, optional parity, 1 or 2 stop bits.
//  Oversamples the line, recovers the data word, checks parity and stop bits, and flags completion.
//  Sits between the Rx pin and the Rx host interface; sample ticks come from the shared baud generator.
// PARAMETERS
//  OVERSAMPLE   16  SampleTick pulses per bit period; must be even and >= 8
//  SYNC_STAGES  2   flops in the RxIn synchroniser; must be >= 2
// PORTS
//  Clock        in   1  system clock; all logic on posedge
//  ResetN       in   1  synchronous active-low reset
//  SampleTick   in   1  one-Clock pulse at OVERSAMPLE x baud; counters advance only on it
//  RxIn         in   1  asynchronous serial line; idles high
//  ParityType   in   2  00/11 no parity bit, 01 odd, 10 even
//  StopBits     in   1  0 = one stop bit, 1 = two stop bits
//  DataLength   in   1  0 = 7 data bits, 1 = 8 data bits
//  RxData       out  8  received word; bit 7 forced 0 in 7-bit mode
//  DataValid    out  1  one-Clock pulse; RxData and error flags updated on the same edge
//  ParityError  out  1  parity mismatch on last frame; held until next DataValid
//  StopError    out  1  any stop-bit sample was 0 on last frame; held until next DataValid
//  ActiveFlag   out  1  high from confirmed start bit until DataValid
//  DoneFlag     out  1  high when idle; low while ActiveFlag is high
// BEHAVIOUR
//  Reset values (ResetN low at posedge): state IDLE; RxData 0; DataValid 0; ParityError 0;
//   StopError 0; ActiveFlag 0; DoneFlag 1. Synchroniser flops and the edge register reset to 1.
//   Reset takes effect mid-frame and discards the partial frame without a DataValid pulse.
//  Synchroniser: RxIn passes SYNC_STAGES flops to give RxS. Falling edge = previous RxS 1 and
//   current RxS 0. Edge detection runs every Clock, not only on SampleTick.
//  Config capture: ParityType, StopBits and DataLength are latched on start detection.
//   Changes to them mid-frame are ignored.
//  Tick counter: 4 bits wide (clog2 OVERSAMPLE). Cleared on start detection; increments on SampleTick;
//   wraps at OVERSAMPLE-1. Bit index counter: 3 bits.
//  FSM:
//   IDLE   : on falling edge -> START; clear tick counter; latch config.
//   START  : on tick count OVERSAMPLE/2-1, sample RxS.
//            If 1: glitch, go to IDLE with no flags.
//            If 0: go to DATA; ActiveFlag 1, DoneFlag 0; clear tick count and bit index.
//   DATA   : every OVERSAMPLE ticks (tick count OVERSAMPLE-1), shift RxS in LSB first.
//            After 7 or 8 bits (per DataLength): go to PARITY if parity is enabled, else STOP.
//   PARITY : sample once. Expected value = XOR of data bits, inverted for odd.
//            Mismatch sets an internal parity error; then go to STOP.
//   STOP   : sample 1 or 2 stop bits. Any 0 sets an internal stop error.
//            After the last stop sample (mid-bit) -> DONE; no wait for end of bit.
//   DONE   : one Clock only. DataValid 1; RxData, ParityError and StopError updated;
//            ActiveFlag 0; DoneFlag 1. Then go to IDLE.
//  Latency: DataValid is asserted 1 Clock after the SampleTick that samples the last stop bit.
//  Back-to-back frames: a start edge arriving right after DONE is accepted; there is no dead time.
//  Stuck-low line (break): frame completes with StopError 1. IDLE then waits for a new
//   1-to-0 edge, so a line held low never retriggers.
//  SampleTick absent: FSM holds state; no timeout.
//  RxData is not cleared between frames; only DataValid marks freshness.
// STRUCTURE
//  Shared package uart_pkg: parity constants PAR_NONE0=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10,
//   PAR_NONE1=2'b11; Rx state encoding; default OVERSAMPLE. The Tx side also uses this package.
//  Sub-module uart_rx_sync: SYNC_STAGES synchroniser plus falling-edge detect; outputs RxS and FallEdge.
//  The rest (FSM, counters, shift register, parity/stop checks) is in this module.
// TESTING (bench drives SampleTick every Clock; OVERSAMPLE=16; frames from the Tx PISO model)
//  1. 8N1, byte 0xA5 -> one DataValid pulse, RxData=0xA5, ParityError=0, StopError=0;
//     DataValid 1 Clock after the stop-bit mid-sample.
//  2. 7E2, data 0x55, correct parity bit 0 -> RxData=0x55, no errors.
//     Same frame with parity bit 1 -> ParityError=1, RxData=0x55.
//  3. 8O1, byte 0x00, stop bit forced 0 -> StopError=1.
//     Line then held low 100 ticks -> no further DataValid.
//  4. Low glitch of 4 ticks in IDLE -> FSM back to IDLE, ActiveFlag stays 0, no DataValid.
//  5. ResetN low for 1 Clock during DATA bit 3 -> all outputs at reset values.
//     Next valid 8N1 frame 0x3C -> received correctly.
//  6. Two 8N1 frames 0x12 then 0x34 with no idle gap; ParityType changed mid-frame 1 ->
//     two DataValid pulses, data 0x12 then 0x34, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the Tx PISO and the Rx SIPO.
// Covers parity encodings, Rx state encoding, the captured frame configuration and parity helpers.
package uart_pkg;

  localparam logic [1:0] PAR_NONE0 = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE1 = 2'b11;

  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_DONE
  } rxState_t;

  typedef struct packed {
    logic [1:0] parityType;
    logic       stopBits;
    logic       dataLength;
  } rxConfig_t;

  function automatic logic parityEnabled(input logic [1:0] parityType);
    return !((parityType == PAR_NONE0) || (parityType == PAR_NONE1));
  endfunction

  // Unused upper data bits are zero in 7-bit mode, so XOR over all 8 bits is safe.
  function automatic logic expectedParity(input logic [7:0] data, input logic [1:0] parityType);
    return (parityType == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the asynchronous Rx line plus a 1-to-0 edge detector.
// Edge detection runs on every Clock, independent of the sample tick.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clock,
  input  logic ResetN,
  input  logic RxIn,
  output logic RxS,
  output logic FallEdge
);

  logic [SYNC_STAGES-1:0] syncReg;
  logic                   prevRxS;

  // Stages reset to 1 so a freshly released design sees an idle line.
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      always_ff @(posedge Clock) begin
        if (!ResetN) syncReg[gi] <= 1'b1;
        else         syncReg[gi] <= RxIn;
      end
    end else begin : g_next
      always_ff @(posedge Clock) begin
        if (!ResetN) syncReg[gi] <= 1'b1;
        else         syncReg[gi] <= syncReg[gi-1];
      end
    end
  end

  assign RxS = syncReg[SYNC_STAGES-1];

  always_ff @(posedge Clock) begin
    if (!ResetN) prevRxS <= 1'b1;
    else         prevRxS <= RxS;
  end

  assign FallEdge = prevRxS & ~RxS;

endmodule

// File: rtl/uart_rx_sipo.sv
// UART receive SIPO: oversampled start/data/parity/stop recovery with error flags.
// Frame configuration is captured at start detection so mid-frame changes are ignored.
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clock,
  input  logic       ResetN,
  input  logic       SampleTick,
  input  logic       RxIn,
  input  logic [1:0] ParityType,
  input  logic       StopBits,
  input  logic       DataLength,
  output logic [7:0] RxData,
  output logic       DataValid,
  output logic       ParityError,
  output logic       StopError,
  output logic       ActiveFlag,
  output logic       DoneFlag
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

  logic rxS;
  logic fallEdge;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .Clock   (Clock),
    .ResetN  (ResetN),
    .RxIn    (RxIn),
    .RxS     (rxS),
    .FallEdge(fallEdge)
  );

  rxState_t          state;
  rxConfig_t         cfg;
  logic [TICK_W-1:0] tickCnt;
  logic [2:0]        bitIdx;
  logic [7:0]        shiftReg;
  logic              parErr;
  logic              stopErr;

  logic       bitEnd;
  logic [2:0] lastDataBit;
  logic [2:0] lastStopBit;

  // bitEnd marks the mid-bit sample point, one full bit period after the previous one.
  assign bitEnd      = SampleTick && (tickCnt == TICK_LAST);
  assign lastDataBit = cfg.dataLength ? 3'd7 : 3'd6;
  assign lastStopBit = cfg.stopBits ? 3'd1 : 3'd0;

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state       <= RX_IDLE;
      cfg         <= '0;
      tickCnt     <= '0;
      bitIdx      <= '0;
      shiftReg    <= '0;
      parErr      <= 1'b0;
      stopErr     <= 1'b0;
      RxData      <= '0;
      DataValid   <= 1'b0;
      ParityError <= 1'b0;
      StopError   <= 1'b0;
      ActiveFlag  <= 1'b0;
      DoneFlag    <= 1'b1;
    end else begin
      DataValid <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (fallEdge) begin
            state   <= RX_START;
            tickCnt <= '0;
            cfg     <= '{parityType: ParityType, stopBits: StopBits, dataLength: DataLength};
          end
        end

        RX_START: begin
          if (SampleTick) begin
            if (tickCnt == TICK_MID) begin
              if (rxS) begin
                state <= RX_IDLE;
              end else begin
                state      <= RX_DATA;
                ActiveFlag <= 1'b1;
                DoneFlag   <= 1'b0;
                tickCnt    <= '0;
                bitIdx     <= '0;
                shiftReg   <= '0;
                parErr     <= 1'b0;
                stopErr    <= 1'b0;
              end
            end else begin
              tickCnt <= tickCnt + TICK_ONE;
            end
          end
        end

        RX_DATA: begin
          if (SampleTick) tickCnt <= bitEnd ? '0 : tickCnt + TICK_ONE;
          if (bitEnd) begin
            shiftReg[bitIdx] <= rxS;
            if (bitIdx == lastDataBit) begin
              bitIdx <= '0;
              state  <= parityEnabled(cfg.parityType) ? RX_PARITY : RX_STOP;
            end else begin
              bitIdx <= bitIdx + 3'd1;
            end
          end
        end

        RX_PARITY: begin
          if (SampleTick) tickCnt <= bitEnd ? '0 : tickCnt + TICK_ONE;
          if (bitEnd) begin
            if (rxS != expectedParity(shiftReg, cfg.parityType)) parErr <= 1'b1;
            state <= RX_STOP;
          end
        end

        // Finish at the last stop mid-sample so the next start edge is never missed.
        RX_STOP: begin
          if (SampleTick) tickCnt <= bitEnd ? '0 : tickCnt + TICK_ONE;
          if (bitEnd) begin
            if (!rxS) stopErr <= 1'b1;
            if (bitIdx == lastStopBit) begin
              state <= RX_DONE;
            end else begin
              bitIdx <= bitIdx + 3'd1;
            end
          end
        end

        RX_DONE: begin
          DataValid   <= 1'b1;
          RxData      <= shiftReg;
          ParityError <= parErr;
          StopError   <= stopErr;
          ActiveFlag  <= 1'b0;
          DoneFlag    <= 1'b1;
          // A start edge landing in this cycle would vanish before IDLE could see it.
          if (fallEdge) begin
            state   <= RX_START;
            tickCnt <= '0;
            cfg     <= '{parityType: ParityType, stopBits: StopBits, dataLength: DataLength};
          end else begin
            state <= RX_IDLE;
          end
        end

        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed bench for uart_rx_sipo: frames are built bit by bit at 16 clocks per bit.
// SampleTick is held high so every Clock is a sample tick.
module tb_uart_rx_sipo;
  import uart_pkg::*;

  logic       Clock = 1'b0;
  logic       ResetN;
  logic       SampleTick;
  logic       RxIn;
  logic [1:0] ParityType;
  logic       StopBits;
  logic       DataLength;
  logic [7:0] RxData;
  logic       DataValid;
  logic       ParityError;
  logic       StopError;
  logic       ActiveFlag;
  logic       DoneFlag;

  uart_rx_sipo #(
    .OVERSAMPLE (16),
    .SYNC_STAGES(2)
  ) dut (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .SampleTick (SampleTick),
    .RxIn       (RxIn),
    .ParityType (ParityType),
    .StopBits   (StopBits),
    .DataLength (DataLength),
    .RxData     (RxData),
    .DataValid  (DataValid),
    .ParityError(ParityError),
    .StopError  (StopError),
    .ActiveFlag (ActiveFlag),
    .DoneFlag   (DoneFlag)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int         dvCount = 0;
  int         dvCycle = -1;
  logic       activeSeen = 1'b0;

  always @(negedge Clock) begin
    if (DataValid) begin
      dvCount = dvCount + 1;
      dvCycle = cyc;
    end
    if (ActiveFlag) activeSeen = 1'b1;
  end

  int nCompared = 0;
  int nMismatch = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_rxdata"}, 32'(RxData), 32'h0);
    check({tag, "_dv"},     32'(DataValid), 32'h0);
    check({tag, "_perr"},   32'(ParityError), 32'h0);
    check({tag, "_serr"},   32'(StopError), 32'h0);
    check({tag, "_active"}, 32'(ActiveFlag), 32'h0);
    check({tag, "_done"},   32'(DoneFlag), 32'h1);
  endtask

  task automatic idle(input int n);
    RxIn = 1'b1;
    repeat (n) @(negedge Clock);
  endtask

  task automatic sendBit(input logic v);
    RxIn = v;
    repeat (16) @(negedge Clock);
  endtask

  // c0 is the first posedge that sees the start bit on RxIn.
  task automatic sendFrame(input logic [7:0] data, input int nData, input logic hasPar,
                           input logic parBit, input int nStop, input logic stopVal,
                           input int chgBit, input logic [1:0] chgVal, output int c0);
    c0 = cyc + 1;
    sendBit(1'b0);
    for (int i = 0; i < nData; i++) begin
      if (i == chgBit) ParityType = chgVal;
      sendBit(data[i]);
    end
    if (hasPar) sendBit(parBit);
    for (int i = 0; i < nStop; i++) sendBit(stopVal);
  endtask

  int c0;

  initial begin
    ResetN     = 1'b0;
    SampleTick = 1'b1;
    RxIn       = 1'b1;
    ParityType = PAR_NONE0;
    StopBits   = 1'b0;
    DataLength = 1'b1;
    repeat (3) @(negedge Clock);
    checkReset("reset");
    ResetN = 1'b1;
    idle(20);

    // 8N1 0xA5: 9 samples after start -> DataValid at c0 + 10 + 16*9 + 1
    activeSeen = 1'b0;
    sendFrame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, -1, 2'b00, c0);
    check("a5_count",  32'(dvCount), 32'd1);
    check("a5_latency", 32'(dvCycle), 32'(c0 + 155));
    check("a5_data",   32'(RxData), 32'hA5);
    check("a5_perr",   32'(ParityError), 32'h0);
    check("a5_serr",   32'(StopError), 32'h0);
    check("a5_active_seen", 32'(activeSeen), 32'h1);
    check("a5_active_after", 32'(ActiveFlag), 32'h0);
    check("a5_done_after", 32'(DoneFlag), 32'h1);
    idle(20);

    // 8O1 0x00, odd parity bit 1 is correct, stop bit forced low, then break
    ParityType = PAR_ODD;
    sendFrame(8'h00, 8, 1'b1, 1'b1, 1, 1'b0, -1, 2'b00, c0);
    check("brk_count",  32'(dvCount), 32'd2);
    check("brk_latency", 32'(dvCycle), 32'(c0 + 171));
    check("brk_data",   32'(RxData), 32'h00);
    check("brk_perr",   32'(ParityError), 32'h0);
    check("brk_serr",   32'(StopError), 32'h1);
    RxIn = 1'b0;
    repeat (100) @(negedge Clock);
    check("brk_hold_count", 32'(dvCount), 32'd2);
    check("brk_hold_active", 32'(ActiveFlag), 32'h0);
    check("brk_hold_done", 32'(DoneFlag), 32'h1);
    idle(20);

    // 4-tick low glitch in IDLE is rejected at the start mid-sample
    activeSeen = 1'b0;
    RxIn = 1'b0;
    repeat (4) @(negedge Clock);
    idle(40);
    check("glitch_count", 32'(dvCount), 32'd2);
    check("glitch_active_seen", 32'(activeSeen), 32'h0);
    check("glitch_done", 32'(DoneFlag), 32'h1);
    check("glitch_serr_held", 32'(StopError), 32'h1);

    // 7E2 0x55 (four ones -> even parity bit 0), then same frame with wrong parity
    ParityType = PAR_EVEN;
    StopBits   = 1'b1;
    DataLength = 1'b0;
    sendFrame(8'h55, 7, 1'b1, 1'b0, 2, 1'b1, -1, 2'b00, c0);
    check("7e2_count",  32'(dvCount), 32'd3);
    check("7e2_latency", 32'(dvCycle), 32'(c0 + 171));
    check("7e2_data",   32'(RxData), 32'h55);
    check("7e2_perr",   32'(ParityError), 32'h0);
    check("7e2_serr",   32'(StopError), 32'h0);
    sendFrame(8'h55, 7, 1'b1, 1'b1, 2, 1'b1, -1, 2'b00, c0);
    check("7e2bad_count", 32'(dvCount), 32'd4);
    check("7e2bad_data", 32'(RxData), 32'h55);
    check("7e2bad_perr", 32'(ParityError), 32'h1);
    check("7e2bad_serr", 32'(StopError), 32'h0);
    idle(20);

    // Reset in the middle of data bit 3 of an 8N1 frame
    ParityType = PAR_NONE0;
    StopBits   = 1'b0;
    DataLength = 1'b1;
    sendBit(1'b0);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    RxIn = 1'b1;
    repeat (8) @(negedge Clock);
    check("mid_active", 32'(ActiveFlag), 32'h1);
    check("mid_done",   32'(DoneFlag), 32'h0);
    ResetN = 1'b0;
    @(negedge Clock);
    checkReset("midrst");
    ResetN = 1'b1;
    idle(200);
    check("midrst_discard", 32'(dvCount), 32'd4);
    sendFrame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1, -1, 2'b00, c0);
    check("3c_count",  32'(dvCount), 32'd5);
    check("3c_latency", 32'(dvCycle), 32'(c0 + 155));
    check("3c_data",   32'(RxData), 32'h3C);
    check("3c_perr",   32'(ParityError), 32'h0);
    check("3c_serr",   32'(StopError), 32'h0);
    idle(20);

    // Back-to-back 8N1 frames; ParityType flipped to even during the first frame
    sendFrame(8'h12, 8, 1'b0, 1'b0, 1, 1'b1, 4, PAR_EVEN, c0);
    check("b2b1_count", 32'(dvCount), 32'd6);
    check("b2b1_data",  32'(RxData), 32'h12);
    check("b2b1_perr",  32'(ParityError), 32'h0);
    check("b2b1_serr",  32'(StopError), 32'h0);
    ParityType = PAR_NONE0;
    sendFrame(8'h34, 8, 1'b0, 1'b0, 1, 1'b1, -1, 2'b00, c0);
    check("b2b2_count", 32'(dvCount), 32'd7);
    check("b2b2_latency", 32'(dvCycle), 32'(c0 + 155));
    check("b2b2_data",  32'(RxData), 32'h34);
    check("b2b2_perr",  32'(ParityError), 32'h0);
    check("b2b2_serr",  32'(StopError), 32'h0);
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
